neuron_eval_ctrl: RTL and testbench
===================================

// Module: neuron_eval_ctrl
// PURPOSE
//  Sequencer for one stochastic neuron datapath (weight generators -> AND -> OR -> sigmoid -> output reg).
//  Holds the weight register bank and reseeds the datapath through its active-low reset.
//  Runs one evaluation window of STREAM_LEN bitstream cycles, discards pipeline warm-up bits and
//  counts the 1s on the neuron output bitstream. Returns the count through a valid/ready handshake.
// PARAMETERS
//  INPUT_SIZE  2    number of neuron inputs = number of weight registers
//  STREAM_LEN  256  evaluation window length in clk cycles (>=1)
//  PIPE_DELAY  2    datapath latency in cycles (sigmoid + output reg); these bits are discarded
// PORTS
//  clk            in   1                 single clock, rising edge
//  rst            in   1                 asynchronous, active-high reset
//  cfg_we         in   1                 weight write strobe
//  cfg_addr       in   $clog2(INPUT_SIZE) weight index
//  cfg_wdata      in   int (32)          weight value (generator threshold)
//  start_valid    in   1                 request one evaluation
//  start_ready    out  1                 high only in IDLE
//  weight_values  out  int [INPUT_SIZE]  to datapath weight inputs
//  dp_n_rst       out  1                 active-low datapath reset/reseed
//  stream_in      in   1                 neuron output bitstream
//  busy           out  1                 high in FLUSH/WARMUP/RUN
//  result_valid   out  1                 result held until accepted
//  result_ready   in   1                 consumer accepts result
//  result_count   out  CW=$clog2(STREAM_LEN+1)  (32 signed if BIPOLAR_DECODE_EN)
// BEHAVIOUR
//  Reset (any time, incl. mid-run): state=IDLE, weights=0, dp_n_rst=0, counters=0,
//   result_valid=0, result_count=0, busy=0, start_ready=1. No result emitted for an aborted run.
//  FSM: IDLE -(start_valid)-> FLUSH -(1 cyc)-> WARMUP -(PIPE_DELAY cyc)-> RUN -(STREAM_LEN cyc)-> DONE
//   -(result_ready)-> IDLE. PIPE_DELAY=0 skips WARMUP (FLUSH->RUN).
//  dp_n_rst=0 in IDLE and FLUSH, 1 in WARMUP/RUN/DONE. Gives every evaluation identical LFSR seeds.
//  RUN: cyc counter 0..STREAM_LEN-1; ones += stream_in each RUN cycle. The count cannot overflow
//   (CW sized for STREAM_LEN).
//  DONE: result_valid=1, result_count stable. Handshake completes on result_valid&&result_ready.
//   Next start is accepted the cycle after return to IDLE (no IDLE bypass).
//  Weights: cfg_we honoured only in IDLE; writes in other states are dropped (no queueing).
//   cfg_addr>=INPUT_SIZE is ignored. Writes take effect next cycle.
//  start_valid and cfg_we in the same IDLE cycle: the write lands and the run uses the new weight.
//  start_valid outside IDLE is ignored (start_ready=0). Requester must hold it.
//  Total latency start-accept -> result_valid = 1 + PIPE_DELAY + STREAM_LEN cycles.
// CONFIGURATION
//  BIPOLAR_DECODE_EN defined: result_count = 2*ones - STREAM_LEN, as a 32-bit signed value
//   (bipolar stochastic decode), computed once on entry to DONE.
//  Not defined: result_count = raw unsigned ones count, CW bits.
// STRUCTURE
//  Package neuron_ctrl_pkg: typedef enum logic [2:0] {IDLE,FLUSH,WARMUP,RUN,DONE} eval_state_t;
//   function count_width(len).
//  One sub-module: ones_counter (enable, clear, bit in, count out) used in RUN. FSM and weight
//   bank stay in this module.
// TESTING
//  1 rst mid-RUN (cycle 100 of 256) -> next cycle IDLE, busy=0, dp_n_rst=0, no result_valid.
//  2 stream_in held 1, STREAM_LEN=256, PIPE_DELAY=2 -> result_count=256 (bipolar: +256),
//    result_valid exactly 259 cycles after accept.
//  3 stream_in held 0 -> count 0 (bipolar: -256). Alternating 1/0 -> 128 (bipolar: 0).
//  4 result_ready low 10 cycles in DONE -> result_valid/count held stable; start_valid ignored
//    until 1 cycle after the handshake.
//  5 cfg_we addr=1 data=5000 during RUN -> weight_values[1] unchanged. Same write in IDLE ->
//    visible next cycle. cfg_addr=INPUT_SIZE -> no change.
//  6 Two back-to-back runs, same weights, real neuron datapath -> identical result_count
//    (reseed check via dp_n_rst).

Source files
------------

// File: rtl/neuron_ctrl_pkg.sv
// Shared types and sizing helpers for the stochastic neuron evaluation controller.
// No logic; pure declarations.
// Imported by neuron_eval_ctrl and ones_counter.
package neuron_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        WARMUP = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } eval_state_t;

    // Bits needed to hold a count of 0..len inclusive.
    function automatic int count_width(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/neuron_eval_ctrl_ones_counter.sv
// Counts 1s on a bitstream while enabled; synchronous clear has priority.
// Latency: count_o reflects a sampled bit one cycle later.
// No backpressure: samples bit_i every enabled cycle.
module ones_counter
    import neuron_ctrl_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         bit_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise add the incoming bit when enabled.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && bit_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/neuron_eval_ctrl.sv
// Sequencer for one stochastic neuron datapath: weight bank, datapath reseed, windowed 1s count.
// Latency: start accept -> result_valid = 1 + PIPE_DELAY + STREAM_LEN cycles.
// Result held in DONE until result_ready; start/cfg writes outside IDLE are dropped. Option: BIPOLAR_DECODE_EN.
module neuron_eval_ctrl
    import neuron_ctrl_pkg::*;
#(
    parameter int INPUT_SIZE = 2,
    parameter int STREAM_LEN = 256,
    parameter int PIPE_DELAY = 2,
    localparam int CW = count_width(STREAM_LEN),
    localparam int AW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
`ifdef BIPOLAR_DECODE_EN
    localparam int RW = 32
`else
    localparam int RW = CW
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [31:0]   cfg_wdata,
    input  logic          start_valid,
    output logic          start_ready,
    output logic [31:0]   weight_values [INPUT_SIZE],
    output logic          dp_n_rst,
    input  logic          stream_in,
    output logic          busy,
    output logic          result_valid,
    input  logic          result_ready,
    output logic [RW-1:0] result_count
);

    eval_state_t   state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   weights_q [INPUT_SIZE];
    logic [RW-1:0] result_q, result_d;
    logic [CW-1:0] ones_cnt;
    logic [CW-1:0] ones_final;
    logic          warm_last;
    logic          run_last;
    logic          cfg_wr;

    assign warm_last  = (cnt_q == 32'(PIPE_DELAY - 1));
    assign run_last   = (cnt_q == 32'(STREAM_LEN - 1));
    assign cfg_wr     = cfg_we && (state_q == IDLE);
    // Include the bit sampled on the final RUN cycle, which the counter has not absorbed yet.
    assign ones_final = ones_cnt + CW'(stream_in);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; PIPE_DELAY of zero goes straight from FLUSH to RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_valid) state_d = FLUSH;
            FLUSH:   state_d = (PIPE_DELAY == 0) ? RUN : WARMUP;
            WARMUP:  if (warm_last) state_d = RUN;
            RUN:     if (run_last) state_d = DONE;
            DONE:    if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state only.
    always_comb begin
        start_ready  = (state_q == IDLE);
        busy         = (state_q == FLUSH) || (state_q == WARMUP) || (state_q == RUN);
        dp_n_rst     = !((state_q == IDLE) || (state_q == FLUSH));
        result_valid = (state_q == DONE);
    end

    // Phase counter restarts from zero on every state change, so it indexes cycles within WARMUP/RUN.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == WARMUP) || (state_q == RUN)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Phase counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    ones_counter #(
        .W (CW)
    ) u_ones (
        .clk     (clk),
        .rst     (rst),
        .en_i    (state_q == RUN),
        .clr_i   (state_q == FLUSH),
        .bit_i   (stream_in),
        .count_o (ones_cnt)
    );

    // Result is latched once on the last RUN cycle so it stays frozen throughout DONE.
    always_comb begin
        result_d = result_q;
        if ((state_q == RUN) && run_last) begin
`ifdef BIPOLAR_DECODE_EN
            result_d = 32'(2 * int'(ones_final)) - 32'(STREAM_LEN);
`else
            result_d = ones_final;
`endif
        end
    end

    // Result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result_count = result_q;

    // Weight bank: writes land only in IDLE; out-of-range addresses match no entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < INPUT_SIZE; i++) weights_q[i] <= '0;
        end else begin
            for (int i = 0; i < INPUT_SIZE; i++) begin
                if (cfg_wr && (int'(cfg_addr) == i)) weights_q[i] <= cfg_wdata;
            end
        end
    end

    // Drive the weight bank straight to the datapath.
    always_comb begin
        for (int i = 0; i < INPUT_SIZE; i++) weight_values[i] = weights_q[i];
    end

endmodule

// File: tb/tb_neuron_eval_ctrl.sv
// Bench for neuron_eval_ctrl with a scoreboard of expected counts and a small LFSR neuron datapath.
// Honours BIPOLAR_DECODE_EN for the expected encoding.
module tb_neuron_eval_ctrl;
    import neuron_ctrl_pkg::*;

    localparam int INPUT_SIZE = 3;
    localparam int STREAM_LEN = 256;
    localparam int PIPE_DELAY = 2;
    localparam int CW  = count_width(STREAM_LEN);
    localparam int AW  = 2;
    localparam int LAT = 1 + PIPE_DELAY + STREAM_LEN;
`ifdef BIPOLAR_DECODE_EN
    localparam int RW = 32;
`else
    localparam int RW = CW;
`endif

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [31:0]   cfg_wdata;
    logic          start_valid;
    logic          start_ready;
    logic [31:0]   weight_values [INPUT_SIZE];
    logic          dp_n_rst;
    logic          stream_in;
    logic          busy;
    logic          result_valid;
    logic          result_ready;
    logic [RW-1:0] result_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_res;
    int          mode;
    logic        alt = 1'b0;

    neuron_eval_ctrl #(
        .INPUT_SIZE (INPUT_SIZE),
        .STREAM_LEN (STREAM_LEN),
        .PIPE_DELAY (PIPE_DELAY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .weight_values (weight_values),
        .dp_n_rst      (dp_n_rst),
        .stream_in     (stream_in),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_count  (result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- neuron datapath model ----------------
    function automatic logic [15:0] seed_of(input int i);
        return 16'hACE1 ^ 16'(i * 32'h1357);
    endfunction

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    logic [15:0] dl [INPUT_SIZE];
    logic        dor, ds1, ds2;

    always_comb begin
        dor = 1'b0;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            if ({16'd0, dl[i]} < weight_values[i]) dor = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!dp_n_rst) begin
            for (int i = 0; i < INPUT_SIZE; i++) dl[i] <= seed_of(i);
            ds1 <= 1'b0;
            ds2 <= 1'b0;
        end else begin
            for (int i = 0; i < INPUT_SIZE; i++) dl[i] <= lstep(dl[i]);
            ds1 <= dor;
            ds2 <= ds1;
        end
    end

    always @(negedge clk) alt <= ~alt;

    assign stream_in = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : (mode == 2) ? alt : ds2;

    // Expected ones in a window: RUN cycle k sees the OR of generators after k LFSR steps.
    function automatic int dp_expect(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [15:0] l [3];
        logic [31:0] w [3];
        int          ones;
        logic        orv;
        w[0] = w0; w[1] = w1; w[2] = w2;
        ones = 0;
        for (int i = 0; i < 3; i++) l[i] = seed_of(i);
        for (int k = 0; k < STREAM_LEN; k++) begin
            orv = 1'b0;
            for (int i = 0; i < 3; i++) if ({16'd0, l[i]} < w[i]) orv = 1'b1;
            if (orv) ones++;
            for (int i = 0; i < 3; i++) l[i] = lstep(l[i]);
        end
        return ones;
    endfunction

    function automatic logic [31:0] enc(input int ones);
`ifdef BIPOLAR_DECODE_EN
        return 32'(2 * ones - STREAM_LEN);
`else
        return 32'(ones);
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
        end
    endtask

    // Scoreboard: pop on every completed result handshake.
    always @(negedge clk) begin
        if (!rst && result_valid && result_ready) begin
            chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("sb_count", 32'(result_count), exp_q.pop_front());
            last_res = 32'(result_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // One evaluation; optional same-cycle weight-0 write, a write attempt mid-RUN, slow result_ready.
    task automatic run_eval(input int m, input logic [31:0] expv, input int ready_delay,
                            input bit poke, input bit wr0, input logic [31:0] w0v);
        int          lat;
        logic [31:0] c0;
        mode = m;
        result_ready = 1'b0;
        chk("start_ready_idle", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        if (wr0) begin cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = w0v; end
        exp_q.push_back(expv);
        tick();
        start_valid = 1'b0;
        cfg_we = 1'b0;
        chk("flush_dp_n_rst", 32'(dp_n_rst), 32'd0);
        chk("flush_busy", 32'(busy), 32'd1);
        lat = 0;
        while (!result_valid && lat < 2000) begin
            if (poke) begin cfg_we = (lat == 100); cfg_addr = 2'd1; cfg_wdata = 32'd5000; end
            tick();
            lat++;
            if (lat == 150) begin
                chk("run_busy", 32'(busy), 32'd1);
                chk("run_dp_n_rst", 32'(dp_n_rst), 32'd1);
                chk("run_start_ready", 32'(start_ready), 32'd0);
            end
        end
        cfg_we = 1'b0;
        chk("latency", 32'(lat), 32'(LAT));
        chk("done_busy", 32'(busy), 32'd0);
        c0 = 32'(result_count);
        for (int i = 0; i < ready_delay; i++) begin
            start_valid = 1'b1;
            tick();
            chk("hold_valid", 32'(result_valid), 32'd1);
            chk("hold_count", 32'(result_count), c0);
            chk("hold_start_ready", 32'(start_ready), 32'd0);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("post_hs_start_ready", 32'(start_ready), 32'd1);
        chk("post_hs_busy", 32'(busy), 32'd0);
        chk("post_hs_valid", 32'(result_valid), 32'd0);
        start_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          seen;
        int          e;
        logic [31:0] r1;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start_valid = 1'b0; result_ready = 1'b0; mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dp_n_rst", 32'(dp_n_rst), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_count", 32'(result_count), 32'd0);
        @(negedge clk) rst = 1'b0;
        tick();
        for (int i = 0; i < INPUT_SIZE; i++) chk("rst_weight", weight_values[i], 32'd0);

        // All ones, with a dropped weight write mid-RUN.
        run_eval(0, enc(STREAM_LEN), 0, 1'b1, 1'b0, 32'd0);
        chk("run_write_dropped", weight_values[1], 32'd0);

        // IDLE write lands next cycle; out-of-range address does nothing.
        wr(2'd1, 32'd5000);
        chk("idle_write_w1", weight_values[1], 32'd5000);
        wr(2'd3, 32'd777);
        chk("oor_w0", weight_values[0], 32'd0);
        chk("oor_w1", weight_values[1], 32'd5000);
        chk("oor_w2", weight_values[2], 32'd0);

        // All zeros with a slow consumer, then alternating bits.
        run_eval(1, enc(0), 10, 1'b0, 1'b0, 32'd0);
        run_eval(2, enc(STREAM_LEN / 2), 0, 1'b0, 1'b0, 32'd0);

        // Abort at RUN cycle 100.
        mode = 0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        repeat (1 + PIPE_DELAY + 100) tick();
        chk("abort_pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_start_ready", 32'(start_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dp_n_rst", 32'(dp_n_rst), 32'd0);
        chk("abort_valid", 32'(result_valid), 32'd0);
        chk("abort_count", 32'(result_count), 32'd0);
        chk("abort_weight", weight_values[1], 32'd0);
        @(negedge clk) rst = 1'b0;
        tick();
        seen = 0;
        repeat (300) begin
            tick();
            if (result_valid) seen = 1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);

        // Real datapath: weight 0 written in the start cycle, two back-to-back runs.
        wr(2'd1, 32'd5000);
        wr(2'd2, 32'd12000);
        e = dp_expect(32'd30000, 32'd5000, 32'd12000);
        run_eval(3, enc(e), 0, 1'b0, 1'b1, 32'd30000);
        chk("same_cycle_w0", weight_values[0], 32'd30000);
        r1 = last_res;
        run_eval(3, enc(e), 0, 1'b0, 1'b0, 32'd0);
        chk("reseed_same", last_res, r1);

        repeat (4) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
